vga_timing: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 25 MHz pixel clock, publishes the current pixel coordinates to the colour/game logic, and drives the Basys3 VGA connector. Colour inputs arrive combinationally from the coordinates; one output register stage aligns sync, blanking and colour. It also provides a one-cycle vertical-blank tick for frame-synchronous game updates.

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing.sv | 103 ++++++++++
 tb/tb_vga_timing.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, coordinates and
// connector signals out.
interface vga_timing_if;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic [9:0] Hcount;
  logic [8:0] Vcount;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       videoActive;
  logic       vblankTick;

  modport master (
    input  Red, Green, Blue,
    output Hcount, Vcount, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, videoActive, vblankTick
  );

  modport slave (
    output Red, Green, Blue,
    input  Hcount, Vcount, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, videoActive, vblankTick
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 VGA timing generator: free-running pixel/line counters, sync and
// blanking decode, and one output register stage aligning sync with colour.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic         CLK25M,
  input  logic         Reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Only the top nibble reaches the 4-bit DAC; blanked pixels must be black.
  function automatic logic [3:0] pixel_nibble(input logic vld, input logic [7:0] c);
    return vld ? c[7:4] : 4'h0;
  endfunction

  logic [9:0] hcnt_p0;
  logic [9:0] vcnt_p0;
  logic       vld_p0;
  logic       hs_n_p0;
  logic       vs_n_p0;
  logic       tick_p0;

  logic [3:0] r_p1;
  logic [3:0] g_p1;
  logic [3:0] b_p1;
  logic       hs_n_p1;
  logic       vs_n_p1;
  logic       vld_p1;
  logic       tick_p1;

  // Stage p0: pixel/line counters and combinational decode of the current position
  always_ff @(posedge CLK25M) begin
    if (Reset) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= '0;
    end else if (hcnt_p0 == H_LAST) begin
      hcnt_p0 <= '0;
      vcnt_p0 <= (vcnt_p0 == V_LAST) ? '0 : vcnt_p0 + 10'd1;
    end else begin
      hcnt_p0 <= hcnt_p0 + 10'd1;
    end
  end

  always_comb begin
    vld_p0  = (hcnt_p0 < H_VIS) && (vcnt_p0 < V_VIS);
    hs_n_p0 = !((hcnt_p0 >= HS_FIRST) && (hcnt_p0 <= HS_LAST));
    vs_n_p0 = !((vcnt_p0 >= VS_FIRST) && (vcnt_p0 <= VS_LAST));
    tick_p0 = (hcnt_p0 == H_VIS_LAST) && (vcnt_p0 == V_VIS_LAST);
  end

  // Stage p1: connector registers; colour is sampled with the sync it belongs to
  always_ff @(posedge CLK25M) begin
    if (Reset) begin
      r_p1    <= 4'h0;
      g_p1    <= 4'h0;
      b_p1    <= 4'h0;
      hs_n_p1 <= 1'b1;
      vs_n_p1 <= 1'b1;
      vld_p1  <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      r_p1    <= pixel_nibble(vld_p0, vga.Red);
      g_p1    <= pixel_nibble(vld_p0, vga.Green);
      b_p1    <= pixel_nibble(vld_p0, vga.Blue);
      hs_n_p1 <= hs_n_p0;
      vs_n_p1 <= vs_n_p0;
      vld_p1  <= vld_p0;
      tick_p1 <= tick_p0;
    end
  end

  assign vga.Hcount      = hcnt_p0;
  assign vga.Vcount      = vcnt_p0[8:0];
  assign vga.VGA_R       = r_p1;
  assign vga.VGA_G       = g_p1;
  assign vga.VGA_B       = b_p1;
  assign vga.VGA_HS      = hs_n_p1;
  assign vga.VGA_VS      = vs_n_p1;
  assign vga.videoActive = vld_p1;
  assign vga.vblankTick  = tick_p1;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for line timing and a narrow-line
// instance (32-pixel lines, standard vertical timing) so whole frames fit in a short run.
module tb_vga_timing;

  logic        clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [23:0] rgb   = '0;
  logic [23:0] rgb_q = '0;
  int          n     = 0;
  int          checks   = 0;
  int          failures = 0;

  localparam int BT = 32;           // narrow instance line length
  localparam int BF = BT * 525;     // narrow instance frame length

  always #20 clk = ~clk;

  vga_timing_if ifa();
  vga_timing_if ifb();

  assign ifa.Red = rgb[23:16];
  assign ifa.Green = rgb[15:8];
  assign ifa.Blue = rgb[7:0];
  assign ifb.Red = rgb[23:16];
  assign ifb.Green = rgb[15:8];
  assign ifb.Blue = rgb[7:0];

  vga_timing dut_a (
    .CLK25M(clk),
    .Reset (Reset),
    .vga   (ifa.master)
  );

  vga_timing #(
    .H_VISIBLE(16),
    .H_FRONT  (4),
    .H_SYNC   (6),
    .H_BACK   (6)
  ) dut_b (
    .CLK25M(clk),
    .Reset (Reset),
    .vga   (ifb.master)
  );

  // Reference: n = clock edges since the last reset edge; colour seen at that edge
  always @(posedge clk) begin
    n     <= Reset ? 0 : n + 1;
    rgb_q <= rgb;
  end

  logic [34:0] obs_a;
  logic [34:0] obs_b;
  assign obs_a = {ifa.Hcount, ifa.Vcount, ifa.VGA_R, ifa.VGA_G, ifa.VGA_B,
                  ifa.VGA_HS, ifa.VGA_VS, ifa.videoActive, ifa.vblankTick};
  assign obs_b = {ifb.Hcount, ifb.Vcount, ifb.VGA_R, ifb.VGA_G, ifb.VGA_B,
                  ifb.VGA_HS, ifb.VGA_VS, ifb.videoActive, ifb.vblankTick};

  // Counts show position k; pins show position k-1 (or reset values when k==0).
  function automatic logic [34:0] model(input int k, input int hv, input int hf, input int hsw,
                                        input int hb, input int vv, input int vf, input int vsw,
                                        input int vb, input logic [23:0] c);
    int ht, vt, ph, pv;
    logic [9:0] h10, v10;
    logic act, hsn, vsn, tk;
    logic [11:0] col;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    h10 = 10'(k % ht);
    v10 = 10'((k / ht) % vt);
    if (k == 0) return {h10, v10[8:0], 12'h000, 4'b1100};
    ph  = (k - 1) % ht;
    pv  = ((k - 1) / ht) % vt;
    act = (ph < hv) && (pv < vv);
    hsn = !((ph >= hv + hf) && (ph < hv + hf + hsw));
    vsn = !((pv >= vv + vf) && (pv < vv + vf + vsw));
    tk  = (ph == hv - 1) && (pv == vv - 1);
    col = act ? {c[23:20], c[15:12], c[7:4]} : 12'h000;
    return {h10, v10[8:0], col, hsn, vsn, act, tk};
  endfunction

  function automatic logic [34:0] model_a(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, rgb_q);
  endfunction

  function automatic logic [34:0] model_b(input int k);
    return model(k, 16, 4, 6, 6, 480, 10, 2, 33, rgb_q);
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rgb = 24'($urandom);
      @(negedge clk);
      checks += 3;
      if (obs_a !== model_a(n)) begin failures++; $display("FAIL reset_model_a got=%h want=%h", obs_a, model_a(n)); end
      if (obs_b !== model_b(n)) begin failures++; $display("FAIL reset_model_b got=%h want=%h", obs_b, model_b(n)); end
      if (obs_a !== {10'd0, 9'd0, 12'h000, 4'b1100}) begin
        failures++; $display("FAIL reset_values_a got=%h want=%h", obs_a, {10'd0, 9'd0, 12'h000, 4'b1100});
      end
    end
    Reset = 1'b0;
    rgb = 24'($urandom);
    @(negedge clk);
    checks += 3;
    if ({ifa.videoActive, ifa.Hcount, ifa.Vcount} !== {1'b1, 10'd1, 9'd0}) begin
      failures++; $display("FAIL first_after_release got act=%b h=%0d v=%0d want act=1 h=1 v=0",
                           ifa.videoActive, ifa.Hcount, ifa.Vcount);
    end
    if (obs_a !== model_a(n)) begin failures++; $display("FAIL release_model_a got=%h want=%h", obs_a, model_a(n)); end
    if (obs_b !== model_b(n)) begin failures++; $display("FAIL release_model_b got=%h want=%h", obs_b, model_b(n)); end
  endtask

  task automatic test_hsync();
    int falls[$];
    int rises[$];
    int act_cnt;
    logic prev;
    act_cnt = 0;
    prev = ifa.VGA_HS;
    if (n <= 800 && ifa.videoActive) act_cnt++;
    for (int i = 0; i < 1700; i++) begin
      rgb = 24'($urandom);
      @(negedge clk);
      checks += 2;
      if (obs_a !== model_a(n)) begin failures++; $display("FAIL hsync_model_a n=%0d got=%h want=%h", n, obs_a, model_a(n)); end
      if (obs_b !== model_b(n)) begin failures++; $display("FAIL hsync_model_b n=%0d got=%h want=%h", n, obs_b, model_b(n)); end
      if (prev && !ifa.VGA_HS) falls.push_back(n);
      if (!prev && ifa.VGA_HS) rises.push_back(n);
      prev = ifa.VGA_HS;
      if (n <= 800 && ifa.videoActive) act_cnt++;
    end
    checks += 4;
    if (falls.size() < 2 || rises.size() < 1) begin
      failures++; $display("FAIL hsync_edges got falls=%0d rises=%0d want >=2 >=1", falls.size(), rises.size());
    end else begin
      if (falls[0] != 657) begin failures++; $display("FAIL hsync_first_fall got=%0d want=657", falls[0]); end
      if (rises[0] - falls[0] != 96) begin failures++; $display("FAIL hsync_width got=%0d want=96", rises[0] - falls[0]); end
      if (falls[1] - falls[0] != 800) begin failures++; $display("FAIL hsync_period got=%0d want=800", falls[1] - falls[0]); end
    end
    if (act_cnt != 640) begin failures++; $display("FAIL active_per_line got=%0d want=640", act_cnt); end
  endtask

  task automatic test_frame();
    int vfalls[$];
    int vrises[$];
    int ticks[$];
    logic prev;
    int line;
    prev = ifb.VGA_VS;
    while (n < 34000) begin
      rgb = 24'($urandom);
      @(negedge clk);
      checks += 2;
      if (obs_a !== model_a(n)) begin failures++; $display("FAIL frame_model_a n=%0d got=%h want=%h", n, obs_a, model_a(n)); end
      if (obs_b !== model_b(n)) begin failures++; $display("FAIL frame_model_b n=%0d got=%h want=%h", n, obs_b, model_b(n)); end
      if (prev && !ifb.VGA_VS) vfalls.push_back(n);
      if (!prev && ifb.VGA_VS) vrises.push_back(n);
      prev = ifb.VGA_VS;
      if (ifb.vblankTick) ticks.push_back(n);
      line = (n / BT) % 525;
      if (n % BF == BF - 1) begin
        checks++;
        if ({ifb.Hcount, ifb.Vcount} !== {10'd31, 9'd12}) begin
          failures++; $display("FAIL wrap_last got h=%0d v=%0d want h=31 v=12", ifb.Hcount, ifb.Vcount);
        end
      end else if (n % BF == 0) begin
        checks++;
        if ({ifb.Hcount, ifb.Vcount} !== {10'd0, 9'd0}) begin
          failures++; $display("FAIL wrap_zero got h=%0d v=%0d want h=0 v=0", ifb.Hcount, ifb.Vcount);
        end
      end else if (line >= 512 && n % BT == 0) begin
        checks++;
        if (ifb.Vcount !== 9'(line - 512)) begin
          failures++; $display("FAIL vcount_alias line=%0d got=%0d want=%0d", line, ifb.Vcount, line - 512);
        end
      end
    end
    checks += 2;
    if (vfalls.size() != 2 || vrises.size() < 1) begin
      failures++; $display("FAIL vsync_edges got falls=%0d rises=%0d want 2 >=1", vfalls.size(), vrises.size());
    end else begin
      if (vfalls[0] != 490 * BT + 1) begin failures++; $display("FAIL vsync_first_fall got=%0d want=%0d", vfalls[0], 490 * BT + 1); end
      if (vrises[0] - vfalls[0] != 2 * BT) begin failures++; $display("FAIL vsync_width got=%0d want=%0d", vrises[0] - vfalls[0], 2 * BT); end
      if (vfalls[1] - vfalls[0] != BF) begin failures++; $display("FAIL vsync_period got=%0d want=%0d", vfalls[1] - vfalls[0], BF); end
    end
    if (ticks.size() != 2) begin
      failures++; $display("FAIL vblank_tick_count got=%0d want=2", ticks.size());
    end else begin
      if (ticks[0] != 479 * BT + 16) begin failures++; $display("FAIL vblank_tick_pos got=%0d want=%0d", ticks[0], 479 * BT + 16); end
      if (ticks[1] - ticks[0] != BF) begin failures++; $display("FAIL vblank_tick_period got=%0d want=%0d", ticks[1] - ticks[0], BF); end
    end
  endtask

  task automatic test_colour_ff();
    logic act_a, act_b;
    int guard;
    rgb = 24'hFFFFFF;
    guard = 0;
    while ((n % BF) != 15700 && guard < 20000) begin
      @(negedge clk);
      guard++;
      act_a = (((n - 1) % 800) < 640) && ((((n - 1) / 800) % 525) < 480);
      act_b = (((n - 1) % BT) < 16) && ((((n - 1) / BT) % 525) < 480);
      checks += 2;
      if ({ifa.videoActive, ifa.VGA_R, ifa.VGA_G, ifa.VGA_B} !== {act_a, act_a ? 12'hFFF : 12'h000}) begin
        failures++; $display("FAIL colour_ff_a n=%0d got act=%b rgb=%h want act=%b", n, ifa.videoActive,
                             {ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}, act_a);
      end
      if ({ifb.videoActive, ifb.VGA_R, ifb.VGA_G, ifb.VGA_B} !== {act_b, act_b ? 12'hFFF : 12'h000}) begin
        failures++; $display("FAIL colour_ff_b n=%0d got act=%b rgb=%h want act=%b", n, ifb.videoActive,
                             {ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}, act_b);
      end
    end
    checks++;
    if (guard >= 20000) begin failures++; $display("FAIL colour_ff_timeout got=%0d want<20000", guard); end
  endtask

  task automatic test_midframe_reset();
    int guard;
    int fall_a;
    logic prev;
    guard = 0;
    while (!(ifb.Hcount == 10'd22 && ifb.Vcount == 9'd491) && guard < 20000) begin
      rgb = 24'($urandom);
      @(negedge clk);
      guard++;
    end
    checks += 2;
    if (guard >= 20000) begin failures++; $display("FAIL midreset_timeout got=%0d want<20000", guard); end
    if ({ifb.VGA_HS, ifb.VGA_VS} !== 2'b00) begin
      failures++; $display("FAIL midreset_in_sync got hs=%b vs=%b want hs=0 vs=0", ifb.VGA_HS, ifb.VGA_VS);
    end
    Reset = 1'b1;
    rgb = 24'($urandom);
    @(negedge clk);
    checks += 2;
    if (obs_b !== {10'd0, 9'd0, 12'h000, 4'b1100}) begin
      failures++; $display("FAIL midreset_values_b got=%h want=%h", obs_b, {10'd0, 9'd0, 12'h000, 4'b1100});
    end
    if (obs_a !== {10'd0, 9'd0, 12'h000, 4'b1100}) begin
      failures++; $display("FAIL midreset_values_a got=%h want=%h", obs_a, {10'd0, 9'd0, 12'h000, 4'b1100});
    end
    Reset = 1'b0;
    fall_a = -1;
    prev = ifa.VGA_HS;
    for (int i = 0; i < 820; i++) begin
      rgb = 24'($urandom);
      @(negedge clk);
      checks += 2;
      if (obs_a !== model_a(n)) begin failures++; $display("FAIL restart_model_a n=%0d got=%h want=%h", n, obs_a, model_a(n)); end
      if (obs_b !== model_b(n)) begin failures++; $display("FAIL restart_model_b n=%0d got=%h want=%h", n, obs_b, model_b(n)); end
      if (prev && !ifa.VGA_HS && fall_a < 0) fall_a = n;
      prev = ifa.VGA_HS;
    end
    checks++;
    if (fall_a != 657) begin failures++; $display("FAIL restart_hsync_fall got=%0d want=657", fall_a); end
  endtask

  task automatic test_back_to_back_reset();
    int run_len, rst_len;
    for (int r = 0; r < 4; r++) begin
      run_len = int'($urandom_range(60, 5));
      rst_len = int'($urandom_range(4, 1));
      for (int i = 0; i < run_len + rst_len; i++) begin
        Reset = (i >= run_len);
        rgb = 24'($urandom);
        @(negedge clk);
        checks += 2;
        if (obs_a !== model_a(n)) begin failures++; $display("FAIL b2b_model_a n=%0d got=%h want=%h", n, obs_a, model_a(n)); end
        if (obs_b !== model_b(n)) begin failures++; $display("FAIL b2b_model_b n=%0d got=%h want=%h", n, obs_b, model_b(n)); end
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rgb = 24'($urandom);
      @(negedge clk);
      checks += 2;
      if (obs_a !== model_a(n)) begin failures++; $display("FAIL b2b_tail_a n=%0d got=%h want=%h", n, obs_a, model_a(n)); end
      if (obs_b !== model_b(n)) begin failures++; $display("FAIL b2b_tail_b n=%0d got=%h want=%h", n, obs_b, model_b(n)); end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_frame();
    test_colour_ff();
    test_midframe_reset();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
